// File: rtl/gpio_sw_debounce_pkg.sv
// Board-level defaults for the slide-switch conditioner feeding the GPIO input half.
package gpio_sw_debounce_pkg;

    localparam int SW_WIDTH        = 16;
    localparam int SW_DEBOUNCE_CYC = 500_000;   // 10 ms at the 50 MHz core clock

endpackage

// File: rtl/gpio_sw_debounce_if.sv
// Debounced switch bus between the conditioner (master) and the GPIO input block (slave).
interface gpio_sw_debounce_if
    import gpio_sw_debounce_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH
);
    logic [WIDTH-1:0] sw_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic             irq_o;
    logic             irq_clr_i;

    modport master (output sw_o, rise_o, fall_o, irq_o, input irq_clr_i);
    modport slave  (input sw_o, rise_o, fall_o, irq_o, output irq_clr_i);
endinterface

// File: rtl/gpio_sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, registered level and edge pulses.
module debounce_bit #(
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic reset_n,
    input  logic sw_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int               CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             sw_q, sw_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample matching the current level restarts the window; the terminal
    // compare stops the counter before it can wrap.
    always_comb begin
        sw_d   = sw_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q != sw_q) begin
            if (cnt_q == CNT_LAST) begin
                sw_d   = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= RESET_VAL;
            s2_q   <= RESET_VAL;
            sw_q   <= RESET_VAL;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= sw_i;
            s2_q   <= s1_q;
            sw_q   <= sw_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_o   = sw_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/gpio_sw_debounce.sv
// Slide-switch conditioner: per-bit debouncers plus a sticky change interrupt.
module gpio_sw_debounce
    import gpio_sw_debounce_pkg::*;
#(
    parameter int               WIDTH         = SW_WIDTH,
    parameter int               STABLE_CYCLES = SW_DEBOUNCE_CYC,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic               clk_i,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   sw_i,
    gpio_sw_debounce_if.master gpio
);
    logic [WIDTH-1:0] sw_w, rise_w, fall_w;
    logic             irq_q, irq_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_bit (
            .clk_i   (clk_i),
            .reset_n (reset_n),
            .sw_i    (sw_i[i]),
            .sw_o    (sw_w[i]),
            .rise_o  (rise_w[i]),
            .fall_o  (fall_w[i])
        );
    end

    // A pulse in the same cycle as a clear still sets the flag, so no event is dropped.
    assign irq_d = (|(rise_w | fall_w)) | (irq_q & ~gpio.irq_clr_i);

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign gpio.sw_o   = sw_w;
    assign gpio.rise_o = rise_w;
    assign gpio.fall_o = fall_w;
    assign gpio.irq_o  = irq_q;
endmodule
